and_unit_arbiter: RTL and testbench

- Shares one 16-bit bitwise-AND datapath between NUM_REQ independent requesters.
- Arbitration is round-robin. The result goes into a single registered output stage with a valid/ready handshake.
- Sits between requester logic and the shared and_gate datapath. It sequences the operations, tags each result with the requester ID, and counts completed operations.

---
 rtl/and_unit_arbiter.sv | 138 +++++++++++++
 tb/tb_and_unit_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/and_unit_arbiter.sv
// ---------------------------------------------------------------------------
// and_unit_arbiter
//
// Shares a single bitwise-AND datapath between NUM_REQ requesters. Requests
// are granted round-robin. Each granted operation is registered in one
// output slot together with the ID of the requester that produced it.
// A 16-bit counter tracks completed response handshakes.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. valid never depends on ready. On the request
// side, req_ready is combinational from req_valid, rsp_ready and the pointer.
// On the response side, rsp_valid/rsp_data/rsp_id come straight from
// registers.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous, active-high reset
//   req_valid  - [NUM_REQ] per-requester request
//   req_ready  - [NUM_REQ] per-requester accept (one-hot or zero)
//   req_a      - [NUM_REQ*DATA_WIDTH] operand A, requester i at [i*DW +: DW]
//   req_b      - [NUM_REQ*DATA_WIDTH] operand B, same packing
//   rsp_valid  - result register holds a valid result
//   rsp_ready  - consumer accepts the result
//   rsp_data   - [DATA_WIDTH] a & b of the granted requester
//   rsp_id     - [ID_WIDTH] index of the producing requester
//   op_count   - [16] completed response handshakes, wraps
//
// ID_WIDTH must equal max(1, clog2(NUM_REQ)); NUM_REQ is legal in 2..8.
// ---------------------------------------------------------------------------
module and_unit_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [15:0]                   op_count
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [ID_WIDTH-1:0]   r_rsp_id;
    logic [15:0]           r_op_count;
    logic [ID_WIDTH-1:0]   r_rr_ptr;

    // -----------------------------------------------------------------------
    // Combinational arbitration
    // -----------------------------------------------------------------------
    logic                  w_slot_free;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_accept;
    logic                  w_rsp_hs;
    logic [ID_WIDTH-1:0]   w_next_ptr;
    logic [DATA_WIDTH-1:0] w_and_result;

    // The slot can take a new result if it is empty or being drained now.
    assign w_slot_free = !r_rsp_valid || rsp_ready;
    assign w_rsp_hs    = r_rsp_valid && rsp_ready;

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ (not at 2**ID_WIDTH,
    // so non-power-of-two NUM_REQ is handled by an explicit subtract).
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_WIDTH'(idx);
            end
        end
    end

    // A grant is only offered where it will be taken: the winner is by
    // construction requesting, so any offered grant is an accept.
    assign w_accept  = !rst && w_slot_free && w_found;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_winner) : '0;

    assign w_next_ptr = (int'(w_winner) == NUM_REQ - 1) ? '0 : (w_winner + 1'b1);

    assign w_and_result = req_a[w_winner*DATA_WIDTH +: DATA_WIDTH]
                        & req_b[w_winner*DATA_WIDTH +: DATA_WIDTH];

    // -----------------------------------------------------------------------
    // Output slot, pointer and counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_accept) begin
                // Also covers the back-to-back case: the slot is overwritten
                // in the same edge that drains it, so rsp_valid stays high.
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_and_result;
                r_rsp_id    <= w_winner;
                r_rr_ptr    <= w_next_ptr;
            end else if (w_rsp_hs) begin
                // Data and ID are left holding their last values.
                r_rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_rsp_hs) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_and_unit_arbiter.sv
`timescale 1ns/1ps
module tb_and_unit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 16;
  localparam int IW      = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_a = '0;
  logic [NUM_REQ*DW-1:0] req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [DW-1:0]         rsp_data;
  logic [IW-1:0]         rsp_id;
  logic [15:0]           op_count;

  int n_checks = 0;
  int n_errors = 0;

  and_unit_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [IW-1:0] id, input logic [15:0] cnt);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    check({tag, ".data"},  32'(rsp_data),  32'(d));
    check({tag, ".id"},    32'(rsp_id),    32'(id));
    check({tag, ".count"}, 32'(op_count),  32'(cnt));
  endtask

  // watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    req_valid = 4'b1111;
    repeat (3) step();
    check("rst.req_ready", 32'(req_ready), 32'h0);
    check_rsp("rst", 1'b0, 16'h0, 2'd0, 16'd0);
    req_valid = '0;
    rst = 1'b0;

    // ---------------- single op ----------------
    set_op(0, 16'hF0F0, 16'hFF00);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    check("single.req_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check_rsp("single.rsp", 1'b1, 16'hF000, 2'd0, 16'd0);
    step();
    check_rsp("single.done", 1'b0, 16'hF000, 2'd0, 16'd1);

    // ---------------- pointer wrap (ptr=1 now) ----------------
    set_op(1, 16'h1234, 16'h00FF);
    req_valid = 4'b0010;
    #1;
    check("wrap.grant1", 32'(req_ready), 32'h2);
    step();
    check_rsp("wrap.rsp1", 1'b1, 16'h0034, 2'd1, 16'd1);
    set_op(0, 16'hAAAA, 16'h0F0F);
    req_valid = 4'b0001;
    #1;
    check("wrap.grant0", 32'(req_ready), 32'h1);
    step();
    check_rsp("wrap.rsp0", 1'b1, 16'h0A0A, 2'd0, 16'd2);
    req_valid = 4'b1111;
    #1;
    // rr_ptr must now be 1
    check("wrap.ptr1", 32'(req_ready), 32'h2);
    req_valid = '0;
    step();
    check_rsp("wrap.drain", 1'b0, 16'h0A0A, 2'd0, 16'd3);

    // ---------------- async reset mid-cycle with pending result ----------------
    set_op(2, 16'hFFFF, 16'h5555);
    req_valid = 4'b0100;
    step();
    check_rsp("arst.pre", 1'b1, 16'h5555, 2'd2, 16'd3);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_rsp("arst.now", 1'b0, 16'h0, 2'd0, 16'd0);
    check("arst.req_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    step();
    rst = 1'b0;

    // ---------------- round-robin fairness ----------------
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 16'hFFFF, 16'(i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    check("rr.first_grant", 32'(req_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      check_rsp($sformatf("rr.%0d", k), 1'b1, 16'(k % 4), 2'(k % 4), 16'(k));
    end

    // ---------------- backpressure (ptr=1) ----------------
    set_op(1, 16'hBEEF, 16'hFFFF);
    req_valid = 4'b0010;
    step();
    check_rsp("bp.load", 1'b1, 16'hBEEF, 2'd1, 16'd5);
    set_op(0, 16'hFFFF, 16'h1111);
    set_op(2, 16'hFFFF, 16'h2222);
    set_op(3, 16'hFFFF, 16'h3333);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp.req_ready%0d", k), 32'(req_ready), 32'h0);
      step();
      check_rsp($sformatf("bp.hold%0d", k), 1'b1, 16'hBEEF, 2'd1, 16'd5);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp.release_grant", 32'(req_ready), 32'h4);
    step();
    check_rsp("bp.next", 1'b1, 16'h2222, 2'd2, 16'd6);
    req_valid = '0;
    step();
    check_rsp("bp.drain", 1'b0, 16'h2222, 2'd2, 16'd7);

    // ---------------- counter wrap ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("cnt.reset", 32'(op_count), 32'h0);
    set_op(0, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    // result appears after edge 1; handshake n completes at edge n+1
    repeat (65536) step();
    check("cnt.ffff", 32'(op_count), 32'hFFFF);
    check("cnt.valid", 32'(rsp_valid), 32'h1);
    step();
    check("cnt.wrap", 32'(op_count), 32'h0);
    req_valid = '0;
    step();
    check("cnt.last", 32'(op_count), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
